// File: rtl/microwave_timer.sv
// rtl/microwave_timer.sv - four-digit BCD countdown timer with keypad entry and expiry pulse
module microwave_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRE_W         = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0] pre;
    logic             sec_tick;
    logic             one_left;

    assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign one_left   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd1);
    assign sec_tick   = enable && !timer_done && (pre == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            pre        <= '0;
            done_pulse <= 1'b0;
        end else if (!clearn) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            pre        <= '0;
            done_pulse <= 1'b0;
        end else if (enable) begin
            done_pulse <= 1'b0;
            if (timer_done) begin
                pre <= '0;
            end else if (sec_tick) begin
                pre        <= '0;
                done_pulse <= one_left;
                // BCD borrow chain; seconds tens above 5 simply count down as entered
                if (sec_ones != 4'd0) begin
                    sec_ones <= sec_ones - 4'd1;
                end else if (sec_tens != 4'd0) begin
                    sec_tens <= sec_tens - 4'd1;
                    sec_ones <= 4'd9;
                end else if (min_ones != 4'd0) begin
                    min_ones <= min_ones - 4'd1;
                    sec_tens <= 4'd5;
                    sec_ones <= 4'd9;
                end else begin
                    min_tens <= min_tens - 4'd1;
                    min_ones <= 4'd9;
                    sec_tens <= 4'd5;
                    sec_ones <= 4'd9;
                end
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end else begin
            // Idle: prescaler parked so each resume starts a full second
            pre        <= '0;
            done_pulse <= 1'b0;
            if (digit_valid && (digit <= 4'd9)) begin
                min_tens <= min_ones;
                min_ones <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= digit;
            end
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
// tb/tb_microwave_timer.sv - directed self-checking bench for microwave_timer
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enable;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic       done_pulse;

    int checks = 0;
    int passes = 0;

    microwave_timer #(.TICKS_PER_SEC(4), .PRE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit      (digit),
        .enable     (enable),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        step(1);
        digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (disp() !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0)
            $display("FAIL reset_init got %h td=%b dp=%b exp 0000 td=1 dp=0", disp(), timer_done, done_pulse);
        else passes++;
        key(4'd7);
        enable = 1'b1;
        step(2);
        checks++;
        if (disp() !== 16'h0007) $display("FAIL reset_preload got %h exp 0007", disp());
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (disp() !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0)
            $display("FAIL reset_async got %h td=%b dp=%b exp 0000 td=1 dp=0", disp(), timer_done, done_pulse);
        else passes++;
        enable = 1'b0;
        #1 rst = 1'b0;
        step(1);
    endtask

    task automatic test_entry();
        do_clear();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        checks++;
        if (disp() !== 16'h1234) $display("FAIL entry_four got %h exp 1234", disp());
        else passes++;
        key(4'd5);
        key(4'd12);
        checks++;
        if (disp() !== 16'h2345) $display("FAIL entry_shift got %h exp 2345", disp());
        else passes++;
        checks++;
        if (timer_done !== 1'b0) $display("FAIL entry_timer_done got %b exp 0", timer_done);
        else passes++;
    endtask

    task automatic test_countdown();
        int bad_steps = 0;
        int bad_pulse = 0;
        logic [15:0] exp_d;
        do_clear();
        key(4'd1); key(4'd0); key(4'd0);
        enable = 1'b1;
        step(3);
        checks++;
        if (disp() !== 16'h0100) $display("FAIL count_first_hold got %h exp 0100", disp());
        else passes++;
        step(1);
        checks++;
        if (disp() !== 16'h0059) $display("FAIL count_first_step got %h exp 0059", disp());
        else passes++;
        for (int k = 2; k <= 60; k++) begin
            step(3);
            if (done_pulse !== 1'b0) bad_pulse++;
            step(1);
            exp_d = {8'h00, 4'((60 - k) / 10), 4'((60 - k) % 10)};
            if (disp() !== exp_d) bad_steps++;
            if (k < 60 && done_pulse !== 1'b0) bad_pulse++;
        end
        checks++;
        if (bad_steps != 0) $display("FAIL count_steps got %0d bad steps exp 0", bad_steps);
        else passes++;
        checks++;
        if (bad_pulse != 0) $display("FAIL count_early_pulse got %0d bad cycles exp 0", bad_pulse);
        else passes++;
        checks++;
        if (disp() !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b1)
            $display("FAIL count_expiry got %h td=%b dp=%b exp 0000 td=1 dp=1", disp(), timer_done, done_pulse);
        else passes++;
        step(1);
        checks++;
        if (done_pulse !== 1'b0) $display("FAIL count_pulse_width got %b exp 0", done_pulse);
        else passes++;
        step(8);
        checks++;
        if (disp() !== 16'h0000 || timer_done !== 1'b1 || done_pulse !== 1'b0)
            $display("FAIL count_zero_hold got %h td=%b dp=%b exp 0000 td=1 dp=0", disp(), timer_done, done_pulse);
        else passes++;
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_pause_resume();
        do_clear();
        key(4'd3);
        enable = 1'b1;
        step(6);
        checks++;
        if (disp() !== 16'h0002) $display("FAIL pause_run got %h exp 0002", disp());
        else passes++;
        enable = 1'b0;
        step(10);
        checks++;
        if (disp() !== 16'h0002) $display("FAIL pause_hold got %h exp 0002", disp());
        else passes++;
        enable = 1'b1;
        step(3);
        checks++;
        if (disp() !== 16'h0002) $display("FAIL resume_full_second got %h exp 0002", disp());
        else passes++;
        step(1);
        checks++;
        if (disp() !== 16'h0001) $display("FAIL resume_step got %h exp 0001", disp());
        else passes++;
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_borrow();
        int bad = 0;
        logic [15:0] exp_d;
        do_clear();
        key(4'd1); key(4'd9); key(4'd0);
        checks++;
        if (disp() !== 16'h0190) $display("FAIL borrow_load got %h exp 0190", disp());
        else passes++;
        enable = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            step(4);
            exp_d = {8'h01, 4'((90 - k) / 10), 4'((90 - k) % 10)};
            if (disp() !== exp_d) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL borrow_odd_seconds got %0d bad steps exp 0", bad);
        else passes++;
        step(4);
        checks++;
        if (disp() !== 16'h0059) $display("FAIL borrow_minute got %h exp 0059", disp());
        else passes++;
        enable = 1'b0;
        do_clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        enable = 1'b1;
        step(4);
        checks++;
        if (disp() !== 16'h0959) $display("FAIL borrow_ten_min got %h exp 0959", disp());
        else passes++;
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_precedence();
        do_clear();
        key(4'd1);
        enable = 1'b1;
        step(3);
        clearn      = 1'b0;
        digit_valid = 1'b1;
        digit       = 4'd5;
        step(1);
        clearn      = 1'b1;
        digit_valid = 1'b0;
        checks++;
        if (disp() !== 16'h0000 || done_pulse !== 1'b0)
            $display("FAIL prec_clear_tick got %h dp=%b exp 0000 dp=0", disp(), done_pulse);
        else passes++;
        step(1);
        checks++;
        if (done_pulse !== 1'b0) $display("FAIL prec_no_late_pulse got %b exp 0", done_pulse);
        else passes++;
        enable = 1'b0;
        key(4'd4); key(4'd2);
        enable = 1'b1;
        key(4'd7);
        checks++;
        if (disp() !== 16'h0042) $display("FAIL prec_entry_while_run got %h exp 0042", disp());
        else passes++;
        enable = 1'b0;
        step(1);
    endtask

    initial begin
        rst         = 1'b1;
        clearn      = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        enable      = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        test_reset();
        test_entry();
        test_countdown();
        test_pause_resume();
        test_borrow();
        test_precedence();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Countdown timer that feeds `timer_done` into the magnetron control stage and consumes that stage's latch output `Q` as its run enable. Keypad digits are shifted into a four-digit BCD M M:S S register while idle. While the magnetron runs, the timer counts down once per second, using an internal prescaler. It reports zero time as a level and reports countdown expiry as a one-cycle pulse for the beeper.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per second; legal range ≥2.
- `PRE_W`, default 7: prescaler width; must satisfy 2^PRE_W ≥ TICKS_PER_SEC.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clearn` in 1: synchronous, active-low clear (keypad CLEAR button, already debounced).
- `digit_valid` in 1: one-cycle strobe; a keypad digit is present on `digit`.
- `digit` in 4: keypad value; only 0–9 are accepted.
- `enable` in 1: run enable, driven by magnetron control `Q`.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: BCD display digits, registered.
- `timer_done` out 1: high whenever all four digits are 0; combinational decode of the digit registers.
- `done_pulse` out 1: registered, one cycle, marks expiry of a countdown.

## Operation
- State: four 4-bit BCD digit registers, a prescaler `pre[PRE_W-1:0]`, and the `done_pulse` flop.
- Update priority each cycle: `rst` > `clearn`=0 > countdown > digit entry.
- Reset (async): all digits 0, `pre`=0, `done_pulse`=0. `timer_done` therefore reads 1.
- Clear (`clearn`=0):
  - Digits go to 0, `pre` goes to 0, `done_pulse` goes to 0.
  - Clear applies regardless of `enable`.
  - A `digit_valid` in the same cycle is dropped.
- Digit entry: accepted only when `enable`=0, `clearn`=1, `digit_valid`=1 and `digit` ≤ 9.
  - Left shift: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit`.
  - The old `min_tens` is discarded.
  - Digits 10–15 are ignored with no state change.
  - `digit_valid` while `enable`=1 is ignored.
- Prescaler:
  - When `enable`=0, `pre` is held at 0, so every resume starts a full second.
  - When `enable`=1 and time is nonzero, `pre` increments each cycle.
  - When `pre`=TICKS_PER_SEC−1, `pre` wraps to 0 and a second-tick occurs in that same cycle.
  - When `enable`=1 and time is zero, `pre` is held at 0.
- Countdown on a second-tick (BCD borrow chain):
  - `sec_ones`>0: decrement `sec_ones`.
  - Else `sec_tens`>0: `sec_tens`−1, `sec_ones`←9.
  - Else `min_ones`>0: `min_ones`−1, `sec_tens`←5, `sec_ones`←9.
  - Else `min_tens`>0: `min_tens`−1, `min_ones`←9, `sec_tens`←5, `sec_ones`←9.
- Keypad-entered seconds tens above 5 (e.g. 1:90) are legal. They count down naturally, 1:90 → 1:89 … 1:00 → 0:59, with no normalisation.
- `done_pulse`=1 for exactly one cycle, in the cycle after a second-tick that changes the digits from 0:01 to 0:00. Zero reached by clear or reset never produces it.
- Zero time with `enable`=1: digits hold, no tick occurs, `timer_done` stays 1. The magnetron logic is responsible for dropping `Q`.
- `enable` falling mid-second (door opened or STOP pressed): digits hold, `pre` returns to 0.

## Timing
- Digits are valid the cycle after the qualifying edge. `timer_done` follows the digits with no extra latency.
- First decrement after `enable` rises (observed on edge E): digits change after edge E+TICKS_PER_SEC−1, giving a period of exactly TICKS_PER_SEC cycles per step thereafter.
- Expiry: the digits show 0:00 and `timer_done` rises in the same cycle. `done_pulse` rises with them, because both come from the same edge, and lasts one cycle.
- `rst` asserted mid-count takes effect immediately and asynchronously. On release, the block is idle at 0:00.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset: assert `rst` mid-count at 0:07 → digits 0:00, `timer_done`=1, `done_pulse`=0 with no clock edge needed.
- Entry: `digit_valid` with 1, 2, 3, 4, 5, then 12 (`enable`=0) → display 23:45; 12 ignored; `timer_done`=0.
- Countdown: load 1:00, `enable`=1 → after 4 cycles 0:59; further 4-cycle steps; digits at 0:00 after 240 cycles, with `done_pulse` high for that single cycle.
- Pause/resume: load 0:03, run 6 cycles (shows 0:02), drop `enable` for 10 cycles (still 0:02), re-enable → 0:01 exactly 4 cycles later.
- Borrow and odd seconds: load 1:90 → steps 1:89 … 1:00 → 0:59; and load 10:00 → 9:59.
- Precedence: `clearn`=0 together with a second-tick and with `digit_valid` → 0:00, no `done_pulse`; `digit_valid` while `enable`=1 → display unchanged.
